// File: rtl/gf180mcu_osu_sc_dff_ctrl_pkg.sv
// gf180mcu_osu_sc_dff_ctrl_pkg: shared state type, MODE bit positions and
// counter sizing helper for the DFF characterisation chain controller.
package gf180mcu_osu_sc_dff_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESET,
        S_GUARD,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_FINISH
    } state_e;

    localparam int MODE_PRESET  = 0;
    localparam int MODE_CAPTURE = 1;

    // Smallest width whose range strictly exceeds chain_len.
    function automatic int cnt_w_for(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_pulse_timer.sv
// gf180mcu_osu_sc_pulse_timer: loadable down-counter with a zero flag,
// used to time the set pulse and the set-recovery guard interval.
module gf180mcu_osu_sc_pulse_timer #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? load_val_i : ((cnt_q != '0) ? cnt_q - W'(1) : cnt_q);

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gf180mcu_osu_sc_12t_dff_chain_ctrl.sv
// gf180mcu_osu_sc_12t_dff_chain_ctrl: preset / scan-load / capture / scan-unload
// sequencer for a chain of set-capable D flip-flops.
module gf180mcu_osu_sc_12t_dff_chain_ctrl
    import gf180mcu_osu_sc_dff_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int CNT_W     = cnt_w_for(CHAIN_LEN),
    parameter int SET_PW    = 4,
    parameter int GUARD     = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [1:0] MODE,
    input  logic       ABORT,
    input  logic       DIN,
    input  logic       DIN_VALID,
    output logic       DIN_READY,
    output logic       DOUT,
    output logic       DOUT_VALID,
    input  logic       DOUT_READY,
    output logic       SCAN_D,
    output logic       SCAN_EN,
    output logic       CHAIN_CE,
    output logic       CHAIN_SN,
    input  logic       SCAN_Q,
    output logic       BUSY,
    output logic       DONE
);

    localparam int TMAX = (SET_PW > GUARD) ? SET_PW : GUARD;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             t_load, t_zero;
    logic [TW-1:0]    t_val;
    logic             last;

    gf180mcu_osu_sc_pulse_timer #(.W(TW)) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (t_load),
        .load_val_i (t_val),
        .zero_o     (t_zero)
    );

    assign last = (cnt_q == CNT_W'(CHAIN_LEN - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        t_load  = 1'b0;
        t_val   = TW'(SET_PW - 1);
        case (state_q)
            S_IDLE: if (START) begin
                mode_d  = MODE;
                cnt_d   = '0;
                t_load  = MODE[MODE_PRESET];
                state_d = MODE[MODE_PRESET] ? S_PRESET : S_SHIFT_IN;
            end
            S_PRESET: if (t_zero) begin
                t_load  = 1'b1;
                t_val   = TW'((GUARD > 0) ? GUARD - 1 : 0);
                state_d = (GUARD > 0) ? S_GUARD : S_SHIFT_IN;
            end
            S_GUARD: if (t_zero) state_d = S_SHIFT_IN;
            S_SHIFT_IN: if (DIN_VALID) begin
                cnt_d = last ? '0 : cnt_q + CNT_W'(1);
                if (last) state_d = mode_q[MODE_CAPTURE] ? S_CAPTURE : S_SHIFT_OUT;
            end
            S_CAPTURE: state_d = S_SHIFT_OUT;
            S_SHIFT_OUT: if (DOUT_READY) begin
                cnt_d = last ? '0 : cnt_q + CNT_W'(1);
                if (last) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over every transition; the current cycle's handshake still stands.
        if (ABORT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end

    // Outputs decode from state only, so async reset forces them immediately.
    assign BUSY       = (state_q != S_IDLE);
    assign DONE       = (state_q == S_FINISH);
    assign CHAIN_SN   = (state_q != S_PRESET);
    assign SCAN_EN    = (state_q != S_CAPTURE);
    assign DIN_READY  = (state_q == S_SHIFT_IN);
    assign DOUT_VALID = (state_q == S_SHIFT_OUT);
    assign SCAN_D     = DIN_READY & DIN;
    assign DOUT       = DOUT_VALID & SCAN_Q;
    assign CHAIN_CE   = (DIN_READY & DIN_VALID) | (state_q == S_CAPTURE) | (DOUT_VALID & DOUT_READY);

endmodule

// File: tb/tb_gf180mcu_osu_sc_12t_dff_chain_ctrl.sv
// tb_gf180mcu_osu_sc_12t_dff_chain_ctrl: directed bench with an 8-flop chain
// model (async set, scan mux, functional D) around the controller.
module tb_gf180mcu_osu_sc_12t_dff_chain_ctrl;

    logic       CLK = 1'b0;
    logic       RST, START, ABORT, DIN, DIN_VALID, DOUT_READY;
    logic [1:0] MODE;
    logic       DIN_READY, DOUT, DOUT_VALID, SCAN_D, SCAN_EN, CHAIN_CE, CHAIN_SN, SCAN_Q, BUSY, DONE;
    logic [7:0] chain_q, func_d;
    logic [8:0] outs;
    int         n_pass = 0, n_total = 0, inv_bad = 0;

    always #5 CLK = ~CLK;

    gf180mcu_osu_sc_12t_dff_chain_ctrl #(
        .CHAIN_LEN(8), .CNT_W(4), .SET_PW(4), .GUARD(1)
    ) dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .ABORT(ABORT),
        .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
        .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY),
        .SCAN_D(SCAN_D), .SCAN_EN(SCAN_EN), .CHAIN_CE(CHAIN_CE), .CHAIN_SN(CHAIN_SN),
        .SCAN_Q(SCAN_Q), .BUSY(BUSY), .DONE(DONE)
    );

    // Chain model: chain_q[0] is the first flop, chain_q[7] drives SCAN_Q.
    always @(posedge CLK or negedge CHAIN_SN)
        if (!CHAIN_SN)     chain_q <= 8'hFF;
        else if (CHAIN_CE) chain_q <= SCAN_EN ? {chain_q[6:0], SCAN_D} : func_d;

    assign SCAN_Q = chain_q[7];
    assign outs   = {CHAIN_SN, CHAIN_CE, SCAN_EN, SCAN_D, DIN_READY, DOUT_VALID, DOUT, BUSY, DONE};

    always @(negedge CLK) begin
        #1;
        if (CHAIN_CE && !CHAIN_SN) inv_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [7:0] pat;
        logic [7:0] fd;
        logic [7:0] exp_dout;
        int         exp_lat;
        int         exp_sn;
        int         exp_cap;
        int         exp_ce;
        int         exp_rdy;
    } vec_t;

    vec_t vecs[5];

    logic [7:0] got;
    int         lat, sn_low, cap, ce, first_rdy, done_cnt, stall_edges;
    logic       busy_after;

    // One full sequence. MODE is flipped and START re-pulsed mid-run and in FINISH;
    // both must be ignored.
    task automatic run_seq(input logic [1:0] m, input logic [7:0] pat, input bit vtog, input int rstall,
                           output logic [7:0] o_got, output int o_lat, output int o_sn, output int o_cap,
                           output int o_ce, output int o_rdy, output int o_done, output int o_stall,
                           output logic o_busy_after);
        int  in_idx = 0, out_n = 0, r_wait = 0;
        bit  fin_start = 0;
        o_got = '0; o_lat = -1; o_sn = 0; o_cap = 0; o_ce = 0; o_rdy = -1;
        o_done = 0; o_stall = 0; o_busy_after = 1'b1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge CLK);
            START = (cyc == 0) || (cyc == 5) || (out_n == 8 && !fin_start);
            if (out_n == 8) fin_start = 1;
            MODE       = (cyc == 0) ? m : ~m;
            DIN        = (in_idx < 8) ? pat[7 - in_idx] : 1'b0;
            DIN_VALID  = !vtog || (cyc % 2 == 1);
            DOUT_READY = ((r_wait % (rstall + 1)) == rstall);
            #1;
            if (!CHAIN_SN) o_sn++;
            if (CHAIN_CE) o_ce++;
            if (CHAIN_CE && !SCAN_EN) o_cap++;
            if (CHAIN_CE && ((DIN_READY && !DIN_VALID) || (DOUT_VALID && !DOUT_READY))) o_stall++;
            if (DIN_READY && o_rdy < 0) o_rdy = cyc;
            if (DIN_READY && DIN_VALID) in_idx++;
            if (DOUT_VALID) begin
                if (DOUT_READY) begin
                    o_got = {o_got[6:0], DOUT};
                    out_n++;
                end
                r_wait++;
            end
            if (DONE) begin
                o_done++;
                if (o_lat < 0) o_lat = cyc;
            end
            if (o_lat >= 0 && cyc == o_lat + 1) o_busy_after = BUSY;
            if (o_lat >= 0 && cyc == o_lat + 3) break;
        end
        START = 0; MODE = 0; DIN_VALID = 0; DOUT_READY = 0; DIN = 0;
    endtask

    initial begin
        int dn;
        RST = 1; START = 0; MODE = 0; ABORT = 0; DIN = 0; DIN_VALID = 0; DOUT_READY = 0; func_d = 8'h00;
        repeat (2) @(negedge CLK);
        #1 check("reset_outs", 32'(outs), 32'h140);
        @(negedge CLK); RST = 0;

        //          mode   pat    fd     dout   lat sn cap ce rdy
        vecs[0] = '{2'b00, 8'hB2, 8'h00, 8'hB2, 17, 0, 0, 16, 1};
        vecs[1] = '{2'b01, 8'h00, 8'hFF, 8'h00, 22, 4, 0, 16, 6};
        vecs[2] = '{2'b10, 8'h3C, 8'hA5, 8'hA5, 18, 0, 1, 17, 1};
        vecs[3] = '{2'b11, 8'h0F, 8'h5A, 8'h5A, 23, 4, 1, 17, 6};
        vecs[4] = '{2'b01, 8'h5A, 8'h00, 8'h5A, 22, 4, 0, 16, 6};

        for (int i = 0; i < 5; i++) begin
            func_d = vecs[i].fd;
            run_seq(vecs[i].mode, vecs[i].pat, 1'b0, 0, got, lat, sn_low, cap, ce, first_rdy, done_cnt, stall_edges, busy_after);
            check($sformatf("v%0d_dout", i), 32'(got), 32'(vecs[i].exp_dout));
            check($sformatf("v%0d_done_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_sn_low_cycles", i), sn_low, vecs[i].exp_sn);
            check($sformatf("v%0d_capture_ce", i), cap, vecs[i].exp_cap);
            check($sformatf("v%0d_ce_total", i), ce, vecs[i].exp_ce);
            check($sformatf("v%0d_first_ready", i), first_rdy, vecs[i].exp_rdy);
            check($sformatf("v%0d_done_pulses", i), done_cnt, 1);
            check($sformatf("v%0d_idle_after", i), 32'(busy_after), 0);
        end

        // Stalled handshakes on both streams.
        func_d = 8'h00;
        run_seq(2'b00, 8'hC6, 1'b1, 3, got, lat, sn_low, cap, ce, first_rdy, done_cnt, stall_edges, busy_after);
        check("stall_dout", 32'(got), 32'hC6);
        check("stall_ce_total", ce, 16);
        check("stall_no_edge", stall_edges, 0);
        check("stall_done_pulses", done_cnt, 1);

        // Abort coincident with the 4th load handshake.
        @(negedge CLK); START = 1; MODE = 2'b00; DIN = 1; DIN_VALID = 1;
        @(negedge CLK); START = 0;
        repeat (2) @(negedge CLK);
        @(negedge CLK); ABORT = 1;
        #1 check("abort_hs_ce", 32'(CHAIN_CE), 1);
        @(negedge CLK); ABORT = 0; DIN_VALID = 0; DIN = 0;
        #1 check("abort_idle", 32'({BUSY, DONE, CHAIN_CE, CHAIN_SN}), 32'b0001);
        check("abort_shifted_bits", 32'(chain_q[3:0]), 32'hF);
        dn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            #1 if (DONE || BUSY) dn++;
        end
        check("abort_stays_idle", dn, 0);
        run_seq(2'b00, 8'h6D, 1'b0, 0, got, lat, sn_low, cap, ce, first_rdy, done_cnt, stall_edges, busy_after);
        check("post_abort_dout", 32'(got), 32'h6D);
        check("post_abort_latency", lat, 17);

        // Async reset in the second PRESET cycle.
        @(negedge CLK); START = 1; MODE = 2'b01;
        @(negedge CLK); START = 0;
        @(negedge CLK);
        #1 check("preset_sn_low", 32'(CHAIN_SN), 0);
        check("preset_chain_set", 32'(chain_q), 32'hFF);
        #2 RST = 1;
        #1 check("rst_async_sn", 32'(CHAIN_SN), 1);
        check("rst_async_outs", 32'(outs), 32'h140);
        START = 1;
        repeat (3) @(negedge CLK);
        #1 check("rst_start_ignored", 32'(outs), 32'h140);
        START = 0;
        @(negedge CLK); RST = 0;
        @(negedge CLK);
        #1 check("post_rst_idle", 32'(outs), 32'h140);

        check("ce_sn_invariant", inv_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gf180mcu_osu_sc_12t_dff_chain_ctrl.md
Name: gf180mcu_osu_sc_12T_dff_chain_ctrl

Overview:
- Sequencer for a characterisation chain of CHAIN_LEN set-capable D flip-flops (active-low async set) wired as a scan shift register.
- Optionally presets the chain with a width-guaranteed active-low set pulse, serially loads a pattern, optionally fires one capture clock, then serially unloads the chain.
- Sits between a test host (valid/ready serial streams) and the flop bank plus its clock-gate cell.

Parameters:
- CHAIN_LEN, 32, number of flops in the chain (≥2).
- CNT_W, 6, bit counter width; must satisfy 2**CNT_W > CHAIN_LEN.
- SET_PW, 4, cycles CHAIN_SN is held low (≥1); meets the set-pin minimum width.
- GUARD, 1, idle cycles after set release before any chain clock (set recovery).

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- START  in  1  begin a sequence; sampled only in IDLE.
- MODE  in  2  bit0 = preset phase enable, bit1 = capture phase enable; latched on START.
- ABORT  in  1  synchronous abort, any state.
- DIN  in  1  serial pattern bit.
- DIN_VALID  in  1  DIN valid.
- DIN_READY  out  1  controller accepts DIN.
- DOUT  out  1  serial unload bit.
- DOUT_VALID  out  1  DOUT valid.
- DOUT_READY  in  1  host accepts DOUT.
- SCAN_D  out  1  chain serial input.
- SCAN_EN  out  1  1 = shift path, 0 = functional capture.
- CHAIN_CE  out  1  clock enable to the chain clock-gate; one chain edge per CE=1 cycle.
- CHAIN_SN  out  1  active-low set to all chain flops.
- SCAN_Q  in  1  chain serial output (last flop).
- BUSY  out  1  1 whenever state ≠ IDLE.
- DONE  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (async, immediate): state = IDLE, counter = 0, mode register = 0. Outputs: CHAIN_SN = 1, CHAIN_CE = 0, SCAN_EN = 1, SCAN_D = 0, DIN_READY = 0, DOUT_VALID = 0, DOUT = 0, BUSY = 0, DONE = 0.
- States: IDLE, PRESET, GUARD, SHIFT_IN, CAPTURE, SHIFT_OUT, FINISH.
- IDLE:
  - START = 1 latches MODE and clears the counter.
  - Next state is PRESET if MODE[0], else SHIFT_IN.
- PRESET:
  - CHAIN_SN = 0 and CHAIN_CE = 0 for exactly SET_PW cycles.
  - Then go to GUARD: CHAIN_SN = 1, CHAIN_CE = 0 for GUARD cycles, then SHIFT_IN.
- SHIFT_IN:
  - DIN_READY = 1 and SCAN_EN = 1; SCAN_D = DIN (combinational).
  - CHAIN_CE = DIN_VALID, i.e. it is asserted only on a handshake cycle; the counter increments on each handshake.
  - After handshake number CHAIN_LEN, go to CAPTURE if MODE[1], else SHIFT_OUT.
  - DIN_VALID low stalls the phase with no chain edge.
- CAPTURE: exactly one cycle with SCAN_EN = 0 and CHAIN_CE = 1; then SHIFT_OUT.
- SHIFT_OUT:
  - DOUT_VALID = 1 and DOUT = SCAN_Q (combinational); SCAN_D = 0, SCAN_EN = 1.
  - CHAIN_CE = DOUT_READY. The first bit presented is the last flop's value, with no leading shift.
  - After CHAIN_LEN handshakes, go to FINISH.
- FINISH: DONE = 1 for one cycle, then IDLE. START during FINISH is ignored.
- The counter wraps to 0 on each phase exit; it never exceeds CHAIN_LEN−1 while a phase is active.
- ABORT has priority over every transition. Next cycle: IDLE, CHAIN_SN = 1, CE = 0, no DONE. A handshake coincident with ABORT still completes for that cycle, including its CE.
- START while BUSY is ignored. MODE changes mid-sequence have no effect.
- RST mid-PRESET releases CHAIN_SN asynchronously; no guard interval is applied.
- Invariant: CHAIN_CE and !CHAIN_SN are never both 1, in every state and cycle.

Decomposition:
- Shared package gf180mcu_osu_sc_dff_ctrl_pkg holds:
  - the state enum;
  - MODE bit-position constants;
  - a function computing CNT_W from CHAIN_LEN.
- One sub-module, gf180mcu_osu_sc_pulse_timer: a loadable down-counter with a zero flag. It is shared by the PRESET and GUARD durations; the bit counter stays in the top level.

Test Plan:
- CHAIN_LEN = 8, MODE = 00, DIN = 10110010 with VALID/READY held high:
  - DOUT emits 10110010 (first-in first-out) over 8 handshakes;
  - DONE pulses exactly once, 17 cycles after START.
- MODE = 01, SET_PW = 4, GUARD = 1, chain model with set:
  - CHAIN_SN low exactly 4 cycles, then 1 guard cycle with CE = 0;
  - an all-zero pattern loaded then unloaded returns 00000000.
- MODE = 10, chain functional D tied to 0xA5:
  - exactly one CE cycle with SCAN_EN = 0;
  - unloaded stream equals the captured 0xA5 bit order.
- DIN_VALID toggled every other cycle and DOUT_READY stalled 3 cycles per bit:
  - CHAIN_CE count equals 16 (two phases × 8);
  - no edge occurs on a stall cycle.
- ABORT mid-SHIFT_IN after 3 bits:
  - next cycle IDLE, BUSY = 0, no DONE;
  - a following START runs a full sequence correctly.
- RST asserted during PRESET (cycle 2):
  - CHAIN_SN = 1 within the same cycle (async);
  - all outputs at reset values; START ignored while RST = 1.
